uart_tx_fifo_unloader: RTL and testbench

UART_TX_FIFO_UNLOADER -- requirements
Module: uart_tx_fifo_unloader

---
 rtl/uart_tx_fifo_unloader.sv | 118 +++++++++++
 tb/tb_uart_tx_fifo_unloader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_unloader.sv
// Pops bytes from a TX FIFO and serialises them as UART frames:
// start, 7/8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_fifo_unloader #(
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  output logic       fifo_read_n,
  output logic       tx,
  output logic       tx_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_WAIT, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t     state, state_nxt;
  logic       armed;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic       started;
  logic       bit8_q, par_en_q, par_q;
  logic       last_bit, last_stop, par_calc;

  assign last_bit  = bit_cnt == (bit8_q ? 3'd7 : 3'd6);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  // bit 7 is masked out of the parity when only 7 data bits go on the line
  assign par_calc  = (^(fifo_data & {bit8, 7'h7f})) ^ odd_n_even;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Holds off the first pop by one edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (armed && !fifo_empty) state_nxt = S_POP;
      S_POP:    state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_START;
      S_START:  if (baud_tick && started) state_nxt = S_DATA;
      S_DATA:   if (baud_tick && last_bit) state_nxt = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (baud_tick) state_nxt = S_STOP;
      S_STOP:   if (baud_tick && last_stop) state_nxt = fifo_empty ? S_IDLE : S_POP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_read_n = (state != S_POP);
    tx_busy     = (state != S_IDLE);
  end

  // tx is updated on the tick that ends the current bit, so it is a plain flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx       <= 1'b1;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      started  <= 1'b0;
      bit8_q   <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          shreg    <= fifo_data;
          bit8_q   <= bit8;
          par_en_q <= parity_en;
          par_q    <= par_calc;
          bit_cnt  <= 3'd0;
          stop_cnt <= 1'b0;
          started  <= 1'b0;
        end
        S_START: if (baud_tick) begin
          if (!started) begin
            started <= 1'b1;
            tx      <= 1'b0;
          end else begin
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end
        end
        S_DATA: if (baud_tick) begin
          if (last_bit) begin
            tx <= par_en_q ? par_q : 1'b1;
          end else begin
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_PARITY: if (baud_tick) tx <= 1'b1;
        S_STOP: if (baud_tick) begin
          tx       <= 1'b1;
          stop_cnt <= last_stop ? 1'b0 : 1'b1;
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_unloader.sv
// Scoreboard bench: two instances (1 and 2 stop bits) fed by FIFO models;
// a negedge monitor decodes tx frames at each baud tick and checks them.
module tb_uart_tx_fifo_unloader;
  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0;
  logic [1:0] fifo_empty, fifo_read_n, tx, tx_busy;
  logic [7:0] fifo_data [2];

  always #5 clock = ~clock;

  uart_tx_fifo_unloader #(.STOP_BITS(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick),
    .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even),
    .fifo_read_n(fifo_read_n[0]), .tx(tx[0]), .tx_busy(tx_busy[0]));

  uart_tx_fifo_unloader #(.STOP_BITS(2)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick),
    .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even),
    .fifo_read_n(fifo_read_n[1]), .tx(tx[1]), .tx_busy(tx_busy[1]));

  int         checks, errors, cyc, rel_cyc;
  bit         force_tick;
  logic [7:0] fq [2][$];
  logic [7:0] stage [2];
  bit         pop_pend [2];
  string      expq [2][$];
  bit         inframe [2];
  string      got [2], want [2];
  int         zr [2], pops [2], pop_cyc [2], last_end [2], last_gap [2];
  int         p_snap [2];

  task automatic chk(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  // Baud tick generator and FIFO model (registered output, two-edge read latency).
  task automatic ticker();
    int tcnt = 0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      baud_tick = force_tick || (tcnt == 0);
      tcnt = (tcnt + 1) % DIV;
      for (int ch = 0; ch < 2; ch++) begin
        fifo_data[ch] = stage[ch];
        if (pop_pend[ch] && fq[ch].size() > 0) stage[ch] = fq[ch].pop_front();
        fifo_empty[ch] = (fq[ch].size() == 0);
      end
    end
  endtask

  task automatic monitor();
    string s, b;
    forever begin
      @(negedge clock);
      for (int ch = 0; ch < 2; ch++) begin
        zr[ch] = tx[ch] ? 0 : zr[ch] + 1;
        pop_pend[ch] = !fifo_read_n[ch];
        if (!reset_n) begin
          inframe[ch] = 1'b0;
        end else begin
          if (!fifo_read_n[ch]) begin
            pops[ch]++;
            last_gap[ch] = cyc - last_end[ch];
            pop_cyc[ch] = cyc;
            chk(!fifo_empty[ch], $sformatf("ch%0d pop_while_empty", ch),
                $sformatf("fifo_empty=%b", fifo_empty[ch]), "fifo_empty=0");
          end
          if (baud_tick) begin
            if (!inframe[ch]) begin
              if (!tx[ch]) begin
                chk(expq[ch].size() != 0, $sformatf("ch%0d unexpected_frame", ch),
                    "start bit", "no frame");
                chk(tx_busy[ch], $sformatf("ch%0d busy_in_frame", ch),
                    $sformatf("%b", tx_busy[ch]), "1");
                chk(zr[ch] == DIV, $sformatf("ch%0d start_len", ch),
                    $sformatf("%0d clocks", zr[ch]), $sformatf("%0d clocks", DIV));
                if (expq[ch].size() != 0) begin
                  s = expq[ch].pop_front();
                  if (ch == 0) want[ch] = {s, "1"};
                  else         want[ch] = {s, "11"};
                  got[ch] = "0";
                  inframe[ch] = 1'b1;
                end
              end
            end else begin
              if (tx[ch]) b = "1";
              else        b = "0";
              got[ch] = {got[ch], b};
              if (got[ch].len() == want[ch].len()) begin
                chk(got[ch] == want[ch], $sformatf("ch%0d frame", ch), got[ch], want[ch]);
                inframe[ch] = 1'b0;
                last_end[ch] = cyc;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic push(input logic [7:0] d, input string frame);
    for (int ch = 0; ch < 2; ch++) begin
      fq[ch].push_back(d);
      expq[ch].push_back(frame);
    end
  endtask

  function automatic bit all_idle();
    return fq[0].size() == 0 && fq[1].size() == 0 && expq[0].size() == 0 &&
           expq[1].size() == 0 && tx_busy == 2'b00 && !inframe[0] && !inframe[1];
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (3) @(negedge clock);
    while (!all_idle() && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk(n < 3000, {tag, "_idle_timeout"}, $sformatf("%0d cycles", n), "< 3000 cycles");
    for (int ch = 0; ch < 2; ch++)
      chk(tx[ch] && !tx_busy[ch], $sformatf("%s ch%0d idle_line", tag, ch),
          $sformatf("tx=%b busy=%b", tx[ch], tx_busy[ch]), "tx=1 busy=0");
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (tx[0] && n < 500);
    chk(!tx[0], {tag, "_start_seen"}, $sformatf("tx=%b", tx[0]), "tx=0");
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) begin
      int m = 0;
      do begin
        @(negedge clock);
        m++;
      end while (!baud_tick && m < 4 * DIV);
    end
  endtask

  task automatic snap();
    for (int ch = 0; ch < 2; ch++) p_snap[ch] = pops[ch];
  endtask

  task automatic chk_pops(input string tag, input int n);
    for (int ch = 0; ch < 2; ch++)
      chk(pops[ch] - p_snap[ch] == n, $sformatf("%s ch%0d pops", tag, ch),
          $sformatf("%0d", pops[ch] - p_snap[ch]), $sformatf("%0d", n));
  endtask

  initial begin
    int low;
    checks = 0; errors = 0; cyc = 0; force_tick = 1'b0;
    fifo_empty = 2'b11;
    for (int ch = 0; ch < 2; ch++) begin
      fifo_data[ch] = 8'h00; stage[ch] = 8'h00; pop_pend[ch] = 1'b0;
      inframe[ch] = 1'b0; zr[ch] = 0; pops[ch] = 0; pop_cyc[ch] = 0;
      last_end[ch] = 0; last_gap[ch] = 0;
    end
    fork
      ticker();
      monitor();
    join_none

    // Reset values while held in reset
    repeat (3) @(negedge clock);
    for (int ch = 0; ch < 2; ch++)
      chk(tx[ch] && !tx_busy[ch] && fifo_read_n[ch], $sformatf("ch%0d reset_outs", ch),
          $sformatf("tx=%b busy=%b rd_n=%b", tx[ch], tx_busy[ch], fifo_read_n[ch]),
          "tx=1 busy=0 rd_n=1");

    // 0x55, 8N: FIFO already holds the byte when reset releases
    snap();
    push(8'h55, "010101010");
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    rel_cyc = cyc;
    wait_idle("single");
    chk_pops("single", 1);
    for (int ch = 0; ch < 2; ch++)
      chk(pop_cyc[ch] - rel_cyc >= 2, $sformatf("ch%0d first_pop_delay", ch),
          $sformatf("%0d edges", pop_cyc[ch] - rel_cyc), ">= 2 edges");

    // 0x83, 7 bits, odd parity
    @(posedge clock); #1;
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
    snap();
    push(8'h83, "011000001");
    wait_idle("odd7");
    chk_pops("odd7", 1);

    // 0x0F, 8 bits, even parity (parity bit 0)
    @(posedge clock); #1;
    bit8 = 1'b1; parity_en = 1'b1; odd_n_even = 1'b0;
    snap();
    push(8'h0f, "0111100000");
    wait_idle("even8");
    chk_pops("even8", 1);

    // Back-to-back 0xA5, 0x3C
    @(posedge clock); #1;
    parity_en = 1'b0;
    snap();
    push(8'ha5, "010100101");
    push(8'h3c, "000111100");
    wait_idle("b2b");
    chk_pops("b2b", 2);
    for (int ch = 0; ch < 2; ch++)
      chk(last_gap[ch] == 1, $sformatf("ch%0d b2b_pop_gap", ch),
          $sformatf("%0d clocks", last_gap[ch]), "1 clock");

    // parity_en rises during DATA of frame 1: only frame 2 carries parity
    snap();
    push(8'h01, "010000000");
    push(8'h02, "0010000001");
    wait_start("cfg");
    wait_ticks(2);
    @(posedge clock); #1 parity_en = 1'b1;
    wait_idle("cfg");
    chk_pops("cfg", 2);

    // Ticks on every clock through POP/WAIT/LOAD
    @(posedge clock); #1;
    parity_en = 1'b0;
    force_tick = 1'b1;
    snap();
    push(8'h55, "010101010");
    begin
      int n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (fifo_read_n[0] && n < 500);
      chk(!fifo_read_n[0], "ticks_pop_seen", $sformatf("rd_n=%b", fifo_read_n[0]), "rd_n=0");
    end
    repeat (2) @(posedge clock);
    #3 force_tick = 1'b0;
    wait_idle("ticks");
    chk_pops("ticks", 1);

    // Reset during data bit 3
    snap();
    push(8'h55, "010101010");
    wait_start("rst");
    wait_ticks(4);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    for (int ch = 0; ch < 2; ch++)
      chk(tx[ch] && !tx_busy[ch] && fifo_read_n[ch], $sformatf("ch%0d async_reset", ch),
          $sformatf("tx=%b busy=%b rd_n=%b", tx[ch], tx_busy[ch], fifo_read_n[ch]),
          "tx=1 busy=0 rd_n=1");
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      low = 0;
      repeat (60) begin
        @(negedge clock);
        if (!tx[ch] || tx_busy[ch]) low++;
      end
      chk(low == 0, $sformatf("ch%0d post_reset_quiet", ch),
          $sformatf("%0d active cycles", low), "0 active cycles");
    end
    chk_pops("rst", 1);

    for (int ch = 0; ch < 2; ch++)
      chk(expq[ch].size() == 0, $sformatf("ch%0d frames_outstanding", ch),
          $sformatf("%0d", expq[ch].size()), "0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
